// File: rtl/replica_pkg.sv
// Shared sizing constants, replica command encoding and controller states
// for the replica exchange controller.
package replica_pkg;

  localparam int REPLICA_NUM = 8;
  localparam int CITY_NUM    = 30;
  localparam int DRAIN_LAT   = 4;

  localparam int GRANT_W  = $clog2(REPLICA_NUM) + 1;
  localparam int STREAM_W = $clog2(CITY_NUM + 1);
  localparam int DRAIN_W  = $clog2(DRAIN_LAT + 1);

  typedef enum logic [1:0] {
    NOP  = 2'd0,
    PREV = 2'd1,
    FOLW = 2'd2,
    SELF = 2'd3
  } replica_command_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    FLIP   = 3'd4
  } exch_state_t;

endpackage

// File: rtl/exchange_pair_decode.sv
// Resolves granted swap pairs from parity and flags into per-replica
// commands plus a count of granted pairs.
module exchange_pair_decode
  import replica_pkg::*;
(
  input  logic                               parity,
  input  logic             [REPLICA_NUM-1:0] flags,
  output replica_command_t [REPLICA_NUM-1:0] cmd,
  output logic             [GRANT_W-1:0]     grant_count
);

  logic [REPLICA_NUM-1:0] mask;
  logic [REPLICA_NUM-1:0] grant;
  logic [REPLICA_NUM-1:0] grant_prev;

  // last replica has no partner, so its mask bit stays clear
  always_comb begin
    mask = '0;
    for (int i = 0; i < REPLICA_NUM - 1; i++)
      mask[i] = (1'(i) == parity);
  end

  assign grant      = flags & mask;
  assign grant_prev = {grant[REPLICA_NUM-2:0], 1'b0};

  always_comb begin
    for (int i = 0; i < REPLICA_NUM; i++) begin
      cmd[i] = SELF;
      unique case (1'b1)
        grant[i]:      cmd[i] = FOLW;
        grant_prev[i]: cmd[i] = PREV;
        default:       cmd[i] = SELF;
      endcase
    end
  end

  always_comb begin
    grant_count = '0;
    for (int i = 0; i < REPLICA_NUM; i++)
      grant_count = grant_count + GRANT_W'(grant[i]);
  end

endmodule

// File: rtl/replica_exchange_ctrl.sv
// Sequences one replica exchange pass: issue commands, stream the
// cities, drain the RAM write pipeline, then flip the read bank.
module replica_exchange_ctrl
  import replica_pkg::*;
(
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               parity,
  input  logic             [REPLICA_NUM-1:0] exchange_flag,
  output replica_command_t [REPLICA_NUM-1:0] command,
  output logic                               rbank,
  output logic                               busy,
  output logic                               done,
  output logic             [15:0]            swap_count
);

  exch_state_t state;
  exch_state_t state_nxt;

  logic [STREAM_W-1:0] stream_cnt;
  logic [DRAIN_W-1:0]  drain_cnt;
  logic                stream_last;
  logic                drain_last;

  replica_command_t [REPLICA_NUM-1:0] dec_cmd;
  logic             [GRANT_W-1:0]     dec_count;

  exchange_pair_decode u_decode (
    .parity      (parity),
    .flags       (exchange_flag),
    .cmd         (dec_cmd),
    .grant_count (dec_count)
  );

  assign stream_last = (stream_cnt == STREAM_W'(CITY_NUM - 1));
  assign drain_last  = (drain_cnt == DRAIN_W'(DRAIN_LAT - 1));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   state_nxt = STREAM;
      STREAM:  if (stream_last) state_nxt = DRAIN;
      DRAIN:   if (drain_last) state_nxt = FLIP;
      FLIP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs are registered from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      stream_cnt <= '0;
      drain_cnt  <= '0;
      rbank      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      swap_count <= '0;
      for (int i = 0; i < REPLICA_NUM; i++)
        command[i] <= NOP;
    end else begin
      state <= state_nxt;

      if (state == STREAM && !stream_last)
        stream_cnt <= stream_cnt + 1'b1;
      else
        stream_cnt <= '0;

      if (state == DRAIN && !drain_last)
        drain_cnt <= drain_cnt + 1'b1;
      else
        drain_cnt <= '0;

      busy <= (state_nxt != IDLE);
      done <= (state_nxt == FLIP);

      if (state_nxt == FLIP)
        rbank <= ~rbank;

      if (state_nxt == ISSUE) begin
        command    <= dec_cmd;
        swap_count <= swap_count + 16'(dec_count);
      end else begin
        for (int i = 0; i < REPLICA_NUM; i++)
          command[i] <= NOP;
      end
    end
  end

endmodule

// File: tb/tb_replica_exchange_ctrl.sv
// Directed scoreboard bench for replica_exchange_ctrl.
module tb_replica_exchange_ctrl;
  import replica_pkg::*;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  logic                   parity;
  logic [7:0]             exchange_flag;
  replica_command_t [7:0] command;
  logic                   rbank;
  logic                   busy;
  logic                   done;
  logic [15:0]            swap_count;
  logic [15:0]            cmd_bits;

  assign cmd_bits = command;

  always #5 clk = ~clk;

  replica_exchange_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .parity        (parity),
    .exchange_flag (exchange_flag),
    .command       (command),
    .rbank         (rbank),
    .busy          (busy),
    .done          (done),
    .swap_count    (swap_count)
  );

  typedef struct {
    logic [15:0] cmd;
    logic [15:0] swap;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic        model_rbank;
  logic [15:0] model_swap;
  logic [15:0] nop_bits;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] predict(input logic par,
                                          input logic [7:0] flg,
                                          output int cnt);
    logic [15:0] c;
    logic        g;
    logic        prev;
    c    = '0;
    cnt  = 0;
    prev = 1'b0;
    for (int i = 0; i < 8; i++) begin
      g = flg[i] && ((i % 2) == int'(par)) && (i < 7);
      if (g) c[2*i +: 2] = FOLW;
      else if (prev) c[2*i +: 2] = PREV;
      else c[2*i +: 2] = SELF;
      if (g) cnt++;
      prev = g;
    end
    return c;
  endfunction

  task automatic send_start(input logic par, input logic [7:0] flg);
    exp_t e;
    int   cnt;
    e.cmd      = predict(par, flg, cnt);
    model_swap = model_swap + 16'(cnt);
    e.swap     = model_swap;
    exp_q.push_back(e);
    parity        = par;
    exchange_flag = flg;
    start         = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_issue(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, ".q_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".cmd"}, {16'd0, cmd_bits}, {16'd0, e.cmd});
      chk({tag, ".swap"}, {16'd0, swap_count}, {16'd0, e.swap});
      chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
    end
  endtask

  task automatic finish_pass(input string tag, input bit poke);
    int bad_cmd;
    int bad_done;
    int bad_busy;
    bad_cmd  = 0;
    bad_done = 0;
    bad_busy = 0;
    for (int k = 2; k <= 35; k++) begin
      tick();
      if (k == 6) start = 1'b0;
      if (cmd_bits !== nop_bits) bad_cmd++;
      if (done !== 1'b0) bad_done++;
      if (busy !== 1'b1) bad_busy++;
      if (poke && k == 5) begin
        start         = 1'b1;
        parity        = 1'b0;
        exchange_flag = 8'hFF;
      end
    end
    chk({tag, ".nop"}, bad_cmd, 0);
    chk({tag, ".early_done"}, bad_done, 0);
    chk({tag, ".busy_run"}, bad_busy, 0);
    tick();
    model_rbank = ~model_rbank;
    chk({tag, ".flip_done"}, {31'd0, done}, 32'd1);
    chk({tag, ".flip_rbank"}, {31'd0, rbank}, {31'd0, model_rbank});
    chk({tag, ".flip_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, ".flip_nop"}, {16'd0, cmd_bits}, {16'd0, nop_bits});
    if (poke) start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, ".post_done"}, {31'd0, done}, 32'd0);
    chk({tag, ".post_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int bad;
    nop_bits      = {8{NOP}};
    model_rbank   = 1'b0;
    model_swap    = '0;
    reset         = 1'b1;
    start         = 1'b1;
    parity        = 1'b0;
    exchange_flag = 8'hFF;
    tick();
    tick();
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.rbank", {31'd0, rbank}, 32'd0);
    chk("rst.swap", {16'd0, swap_count}, 32'd0);
    chk("rst.cmd", {16'd0, cmd_bits}, {16'd0, nop_bits});
    reset = 1'b0;
    start = 1'b0;
    tick();
    chk("rst.idle", {31'd0, busy}, 32'd0);

    send_start(1'b0, 8'b0000_0101);
    check_issue("p1");
    chk("p1.cmd_ref", {16'd0, cmd_bits},
        {16'd0, SELF, SELF, SELF, SELF, PREV, FOLW, PREV, FOLW});
    chk("p1.swap_ref", {16'd0, swap_count}, 32'd2);
    finish_pass("p1", 1'b0);

    send_start(1'b1, 8'b1000_0010);
    check_issue("p2");
    chk("p2.cmd_ref", {16'd0, cmd_bits},
        {16'd0, SELF, SELF, SELF, SELF, SELF, PREV, FOLW, SELF});
    chk("p2.swap_ref", {16'd0, swap_count}, 32'd3);
    finish_pass("p2", 1'b1);

    send_start(1'b1, 8'h0A);
    check_issue("p_rst");
    for (int k = 2; k <= 10; k++) tick();
    reset = 1'b1;
    tick();
    reset       = 1'b0;
    model_swap  = '0;
    model_rbank = 1'b0;
    chk("mid_rst.busy", {31'd0, busy}, 32'd0);
    chk("mid_rst.done", {31'd0, done}, 32'd0);
    chk("mid_rst.rbank", {31'd0, rbank}, 32'd0);
    chk("mid_rst.swap", {16'd0, swap_count}, 32'd0);
    chk("mid_rst.cmd", {16'd0, cmd_bits}, {16'd0, nop_bits});
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("mid_rst.quiet", bad, 0);

    send_start(1'b0, 8'hFF);
    check_issue("b1");
    chk("b1.swap_ref", {16'd0, swap_count}, 32'd4);
    finish_pass("b1", 1'b0);
    send_start(1'b1, 8'hFF);
    check_issue("b2");
    chk("b2.swap_ref", {16'd0, swap_count}, 32'd7);
    finish_pass("b2", 1'b0);
    send_start(1'b0, 8'hFF);
    check_issue("b3");
    chk("b3.swap_ref", {16'd0, swap_count}, 32'd11);
    finish_pass("b3", 1'b0);

    chk("sb.drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
